// File: rtl/rival_car_scheduler.sv
// Rival-car scheduler: spawns up to two rival cars into fixed lanes, steps them down
// the road on frame ticks, retires them into the score and freezes on player overlap.
module rival_car_scheduler #(
  parameter logic [9:0] LANE0_X        = 10'd248,
  parameter logic [9:0] LANE1_X        = 10'd274,
  parameter logic [9:0] LANE2_X        = 10'd300,
  parameter logic [9:0] SPAWN_Y        = 10'd150,
  parameter logic [9:0] DESPAWN_Y      = 10'd390,
  parameter logic [9:0] PLAYER_Y       = 10'd300,
  parameter int         CAR_W          = 14,
  parameter int         CAR_H          = 16,
  parameter int         STEP_FRAMES    = 3,
  parameter int         SPAWN_INTERVAL = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       clear,
  input  logic [9:0] player_x,
  output logic [1:0] rival_valid,
  output logic [9:0] rival0_x,
  output logic [9:0] rival0_y,
  output logic [9:0] rival1_x,
  output logic [9:0] rival1_y,
  output logic       collide,
  output logic [7:0] score
);
  // state | meaning
  // IDLE  | stopped, waiting for enable
  // RUN   | rivals spawn, step and retire on enabled frame ticks
  // CRASH | overlap seen, everything frozen until clear or reset
  typedef enum logic [1:0] {IDLE, RUN, CRASH} state_t;

  localparam logic [7:0]  STEP_LAST  = 8'(STEP_FRAMES - 1);
  localparam logic [7:0]  SPAWN_LAST = 8'(SPAWN_INTERVAL - 1);
  localparam logic [10:0] CAR_W_L    = 11'(CAR_W);
  localparam logic [10:0] CAR_H_L    = 11'(CAR_H);
  localparam logic [7:0]  LFSR_SEED  = 8'hA5;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] step_q, step_d;
  logic [7:0] spawn_q, spawn_d;
  logic [7:0] score_q, score_d;
  logic [1:0] valid_q, valid_d;
  logic [9:0] x_q [2];
  logic [9:0] x_d [2];
  logic [9:0] y_q [2];
  logic [9:0] y_d [2];
  logic       collide_q, collide_d;
  logic [1:0] hit;
  logic       do_step;
  logic [1:0] retired;
  logic [8:0] score_sum;

  function automatic logic [10:0] absdiff(input logic [9:0] a, input logic [9:0] b);
    absdiff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

  function automatic logic [9:0] lane_x(input logic [1:0] sel);
    case (sel)
      2'd0:    lane_x = LANE0_X;
      2'd2:    lane_x = LANE2_X;
      default: lane_x = LANE1_X;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit[i] = valid_q[i] && (absdiff(x_q[i], player_x) < CAR_W_L)
                          && (absdiff(y_q[i], PLAYER_Y) < CAR_H_L);
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    step_d    = step_q;
    spawn_d   = spawn_q;
    score_d   = score_q;
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    collide_d = collide_q;
    do_step   = 1'b0;
    retired   = 2'd0;
    score_sum = 9'd0;
    case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        if (|hit) begin
          state_d   = CRASH;
          collide_d = 1'b1;
        end else if (enable && frame_tick) begin
          lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
          do_step = (step_q == STEP_LAST);
          step_d  = do_step ? 8'd0 : step_q + 8'd1;
          for (int i = 0; i < 2; i++) begin
            if (do_step && valid_q[i]) begin
              y_d[i] = y_q[i] + 10'd1;
              if (y_d[i] == DESPAWN_Y) begin
                valid_d[i] = 1'b0;
                x_d[i]     = '0;
                y_d[i]     = '0;
                retired    = retired + 2'd1;
              end
            end
          end
          score_sum = {1'b0, score_q} + {7'd0, retired};
          score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
          // Freeness uses valid_q, so a slot retired on this tick is not refilled until the next one.
          if (spawn_q == SPAWN_LAST) begin
            if (!valid_q[0]) begin
              valid_d[0] = 1'b1;
              x_d[0]     = lane_x(lfsr_q[1:0]);
              y_d[0]     = SPAWN_Y;
              spawn_d    = 8'd0;
            end else if (!valid_q[1]) begin
              valid_d[1] = 1'b1;
              x_d[1]     = lane_x(lfsr_q[1:0]);
              y_d[1]     = SPAWN_Y;
              spawn_d    = 8'd0;
            end
          end else begin
            spawn_d = spawn_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
    if (clear) begin
      state_d   = IDLE;
      lfsr_d    = LFSR_SEED;
      step_d    = 8'd0;
      spawn_d   = 8'd0;
      score_d   = 8'd0;
      valid_d   = 2'd0;
      collide_d = 1'b0;
      for (int i = 0; i < 2; i++) begin
        x_d[i] = '0;
        y_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      step_q    <= 8'd0;
      spawn_q   <= 8'd0;
      score_q   <= 8'd0;
      valid_q   <= 2'd0;
      collide_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      step_q    <= step_d;
      spawn_q   <= spawn_d;
      score_q   <= score_d;
      valid_q   <= valid_d;
      collide_q <= collide_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign rival_valid = valid_q;
  assign rival0_x    = x_q[0];
  assign rival0_y    = y_q[0];
  assign rival1_x    = x_q[1];
  assign rival1_y    = y_q[1];
  assign collide     = collide_q;
  assign score       = score_q;
endmodule
